draw_request_arbiter: RTL and testbench

//  Shares the single box drawer among four draw requesters: background clear, left paddle, right paddle, ball.

---
 rtl/draw_request_arbiter.sv | 148 ++++++++++++++
 tb/tb_draw_request_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_request_arbiter.sv
// Arbitrates four box-draw requesters onto the single box drawer, one box at a time.
// Holds the grant until the drawer returns ready, then pulses the winner's s_done.
//
// state   | meaning
// S_IDLE  | choosing a winner from s_valid, s_ready driven combinationally
// S_ISSUE | m_valid high with latched box, waiting for drawer handshake
// S_BUSY  | drawer plotting; wait for m_ready (from 2nd cycle) or timeout
module draw_request_arbiter #(
    parameter bit          BG_PRIORITY  = 1'b1,
    parameter logic [31:0] BUSY_TIMEOUT = 32'd20000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  s_valid,
    output logic [3:0]  s_ready,
    input  logic [35:0] s_box_x,
    input  logic [35:0] s_box_y,
    input  logic [35:0] s_box_w,
    input  logic [35:0] s_box_h,
    input  logic [11:0] s_box_color,
    output logic [3:0]  s_done,
    input  logic        m_ready,
    output logic        m_valid,
    output logic [8:0]  m_box_x,
    output logic [8:0]  m_box_y,
    output logic [8:0]  m_box_w,
    output logic [8:0]  m_box_h,
    output logic [2:0]  m_box_color,
    output logic [1:0]  grant_id,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  last_grant_q;
    logic [1:0]  grant_id_q;
    logic        m_valid_q;
    logic [8:0]  m_box_x_q;
    logic [8:0]  m_box_y_q;
    logic [8:0]  m_box_w_q;
    logic [8:0]  m_box_h_q;
    logic [2:0]  m_box_color_q;
    logic [3:0]  s_done_q;
    logic [31:0] busy_cnt_q;
    logic        timeout_err_q;

    logic [1:0]  winner;
    logic [1:0]  cand;
    logic        busy_hit_timeout;

    // Scan downward so the nearest position after last_grant_q overwrites the rest.
    always_comb begin
        winner = last_grant_q;
        cand   = '0;
        for (int k = 4; k >= 1; k--) begin
            cand = last_grant_q + 2'(k);
            if (s_valid[cand]) begin
                winner = cand;
            end
        end
        if (BG_PRIORITY && s_valid[0]) begin
            winner = 2'd0;
        end
    end

    always_comb begin
        s_ready = 4'b0000;
        if (reset_n && (state_q == S_IDLE) && (|s_valid)) begin
            s_ready = 4'b0001 << winner;
        end
    end

    assign busy_hit_timeout = ((busy_cnt_q + 32'd1) >= BUSY_TIMEOUT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 2'd3;
            grant_id_q    <= 2'd0;
            m_valid_q     <= 1'b0;
            m_box_x_q     <= '0;
            m_box_y_q     <= '0;
            m_box_w_q     <= '0;
            m_box_h_q     <= '0;
            m_box_color_q <= '0;
            s_done_q      <= '0;
            busy_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            s_done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (|s_ready) begin
                        m_box_x_q     <= s_box_x[9*winner +: 9];
                        m_box_y_q     <= s_box_y[9*winner +: 9];
                        m_box_w_q     <= s_box_w[9*winner +: 9];
                        m_box_h_q     <= s_box_h[9*winner +: 9];
                        m_box_color_q <= s_box_color[3*winner +: 3];
                        grant_id_q    <= winner;
                        last_grant_q  <= winner;
                        m_valid_q     <= 1'b1;
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (m_valid_q && m_ready) begin
                        m_valid_q  <= 1'b0;
                        busy_cnt_q <= '0;
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (busy_cnt_q != BUSY_TIMEOUT) begin
                        busy_cnt_q <= busy_cnt_q + 32'd1;
                    end
                    // busy_cnt_q == 0 marks the first busy cycle, where ready is still the stale accept.
                    if ((busy_cnt_q != 32'd0) && m_ready) begin
                        s_done_q <= 4'b0001 << grant_id_q;
                        state_q  <= S_IDLE;
                    end else if (busy_hit_timeout) begin
                        timeout_err_q <= 1'b1;
                        s_done_q      <= 4'b0001 << grant_id_q;
                        state_q       <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign m_valid     = m_valid_q;
    assign m_box_x     = m_box_x_q;
    assign m_box_y     = m_box_y_q;
    assign m_box_w     = m_box_w_q;
    assign m_box_h     = m_box_h_q;
    assign m_box_color = m_box_color_q;
    assign grant_id    = grant_id_q;
    assign s_done      = s_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_draw_request_arbiter.sv
// Directed bench for draw_request_arbiter: one strict-background instance (_b) and one
// plain round-robin instance (_r), both with a short busy timeout, sharing requester inputs.
module tb_draw_request_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  s_valid = 4'b0000;
    logic [35:0] s_box_x = '0, s_box_y = '0, s_box_w = '0, s_box_h = '0;
    logic [11:0] s_box_color = '0;

    logic [3:0] s_ready_b, s_done_b, s_ready_r, s_done_r;
    logic       m_ready_b, m_valid_b, terr_b, m_ready_r, m_valid_r, terr_r;
    logic [8:0] mx_b, my_b, mw_b, mh_b, mx_r, my_r, mw_r, mh_r;
    logic [2:0] mc_b, mc_r;
    logic [1:0] gid_b, gid_r;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    draw_request_arbiter #(.BG_PRIORITY(1'b1), .BUSY_TIMEOUT(32'd16)) dut_b (
        .clock(clock), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready_b),
        .s_box_x(s_box_x), .s_box_y(s_box_y), .s_box_w(s_box_w), .s_box_h(s_box_h),
        .s_box_color(s_box_color), .s_done(s_done_b), .m_ready(m_ready_b),
        .m_valid(m_valid_b), .m_box_x(mx_b), .m_box_y(my_b), .m_box_w(mw_b),
        .m_box_h(mh_b), .m_box_color(mc_b), .grant_id(gid_b), .timeout_err(terr_b)
    );

    draw_request_arbiter #(.BG_PRIORITY(1'b0), .BUSY_TIMEOUT(32'd16)) dut_r (
        .clock(clock), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready_r),
        .s_box_x(s_box_x), .s_box_y(s_box_y), .s_box_w(s_box_w), .s_box_h(s_box_h),
        .s_box_color(s_box_color), .s_done(s_done_r), .m_ready(m_ready_r),
        .m_valid(m_valid_r), .m_box_x(mx_r), .m_box_y(my_r), .m_box_w(mw_r),
        .m_box_h(mh_r), .m_box_color(mc_r), .grant_id(gid_r), .timeout_err(terr_r)
    );

    // Behavioural drawers: drop ready on accept, return it after drw_len cycles.
    logic drw_en_b = 1'b1;
    logic man_rdy_b = 1'b1;
    logic drw_rdy_b, drw_rdy_r;
    int   drw_cnt_b, drw_cnt_r;
    int   drw_len = 3;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drw_rdy_b <= 1'b1;
            drw_cnt_b <= 0;
        end else if (drw_en_b) begin
            if (m_valid_b && m_ready_b) begin
                drw_rdy_b <= 1'b0;
                drw_cnt_b <= drw_len;
            end else if (!drw_rdy_b) begin
                if (drw_cnt_b == 0) drw_rdy_b <= 1'b1;
                else drw_cnt_b <= drw_cnt_b - 1;
            end
        end
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drw_rdy_r <= 1'b1;
            drw_cnt_r <= 0;
        end else if (m_valid_r && m_ready_r) begin
            drw_rdy_r <= 1'b0;
            drw_cnt_r <= drw_len;
        end else if (!drw_rdy_r) begin
            if (drw_cnt_r == 0) drw_rdy_r <= 1'b1;
            else drw_cnt_r <= drw_cnt_r - 1;
        end
    end

    assign m_ready_b = drw_en_b ? drw_rdy_b : man_rdy_b;
    assign m_ready_r = drw_rdy_r;

    function automatic int idx_of(input logic [3:0] v);
        case (v)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 9;
        endcase
    endfunction

    int glog_b[64], glog_r[64], dlog_r[64];
    int gcnt_b = 0, gcnt_r = 0, dcnt_r = 0;

    always @(posedge clock) begin
        if (reset_n && (|(s_ready_b & s_valid)) && gcnt_b < 64) begin
            glog_b[gcnt_b] <= idx_of(s_ready_b);
            gcnt_b <= gcnt_b + 1;
        end
        if (reset_n && (|(s_ready_r & s_valid)) && gcnt_r < 64) begin
            glog_r[gcnt_r] <= idx_of(s_ready_r);
            gcnt_r <= gcnt_r + 1;
        end
        if (reset_n && (|s_done_r) && dcnt_r < 64) begin
            dlog_r[dcnt_r] <= idx_of(s_done_r);
            dcnt_r <= dcnt_r + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic set_box(input int i, input int x, input int y, input int w, input int h,
                           input int c);
        s_box_x[9*i +: 9]     = 9'(x);
        s_box_y[9*i +: 9]     = 9'(y);
        s_box_w[9*i +: 9]     = 9'(w);
        s_box_h[9*i +: 9]     = 9'(h);
        s_box_color[3*i +: 3] = 3'(c);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        s_valid = 4'b0000;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Returns the first nonzero s_done_b seen at a negedge, or 0 if none within the budget.
    task automatic wait_done_b(output logic [3:0] d);
        d = 4'b0000;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (s_done_b != 4'b0000) begin
                d = s_done_b;
                break;
            end
        end
    endtask

    task automatic wait_count(input string tag, input bit use_r, input bit use_done,
                              input int target);
        int n;
        for (n = 0; n < 400; n++) begin
            @(negedge clock);
            if (use_done && dcnt_r >= target) break;
            if (!use_done && use_r && gcnt_r >= target) break;
            if (!use_done && !use_r && gcnt_b >= target) break;
        end
        chk(tag, 32'(n < 400), 32'd1);
    endtask

    logic [3:0] d;
    int st_b, st_r, nt;

    initial begin
        for (int i = 0; i < 4; i++) set_box(i, 10*i + 1, 20*i + 2, 4 + i, 5 + i, i + 1);

        // Reset values, s_ready forced low during reset
        s_valid = 4'b0001;
        #12;
        chk("rst_s_ready", s_ready_b, 4'b0000);
        chk("rst_m_valid", m_valid_b, 1'b0);
        chk("rst_m_box_x", mx_b, 9'd0);
        chk("rst_grant_id", gid_b, 2'd0);
        chk("rst_s_done", s_done_b, 4'b0000);
        chk("rst_timeout", terr_b, 1'b0);
        s_valid = 4'b0000;
        @(negedge clock);
        reset_n = 1'b1;

        // 1: single request from requester 1
        @(negedge clock);
        set_box(1, 20, 30, 2, 48, 7);
        s_valid = 4'b0010;
        #1 chk("t1_s_ready", s_ready_b, 4'b0010);
        @(negedge clock);
        s_valid = 4'b0000;
        chk("t1_m_valid", m_valid_b, 1'b1);
        chk("t1_x", mx_b, 9'd20);
        chk("t1_y", my_b, 9'd30);
        chk("t1_w", mw_b, 9'd2);
        chk("t1_h", mh_b, 9'd48);
        chk("t1_c", mc_b, 3'd7);
        chk("t1_gid", gid_b, 2'd1);
        chk("t1_s_ready_issue", s_ready_b, 4'b0000);
        wait_done_b(d);
        chk("t1_done", d, 4'b0010);
        @(negedge clock);
        chk("t1_done_one_cycle", s_done_b, 4'b0000);

        // 2: round-robin over 1,2,3 with requests held
        pulse_reset();
        st_r = gcnt_r;
        nt = dcnt_r;
        s_valid = 4'b1110;
        wait_count("t2_grant_wait", 1'b1, 1'b0, st_r + 6);
        wait_count("t2_done_wait", 1'b1, 1'b1, nt + 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t2_grant%0d", k), glog_r[st_r + k], (k % 3) + 1);
            chk($sformatf("t2_done%0d", k), dlog_r[nt + k], (k % 3) + 1);
        end

        // 3: background priority vs plain round-robin with all four requesting
        pulse_reset();
        st_b = gcnt_b;
        st_r = gcnt_r;
        s_valid = 4'b1111;
        wait_count("t3_bg_wait", 1'b0, 1'b0, st_b + 3);
        s_valid = 4'b1110;
        wait_count("t3_bg_wait2", 1'b0, 1'b0, st_b + 6);
        wait_count("t3_rr_wait", 1'b1, 1'b0, st_r + 4);
        for (int k = 0; k < 6; k++)
            chk($sformatf("t3_bg_grant%0d", k), glog_b[st_b + k], (k < 3) ? 0 : k - 2);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t3_rr_grant%0d", k), glog_r[st_r + k], k);

        // 4: back-pressure in S_ISSUE, zero-width box, pending request waits
        pulse_reset();
        drw_en_b = 1'b0;
        man_rdy_b = 1'b0;
        set_box(2, 300, 200, 0, 511, 5);
        s_valid = 4'b0100;
        #1 chk("t4_s_ready", s_ready_b, 4'b0100);
        @(negedge clock);
        s_valid = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t4_m_valid%0d", k), m_valid_b, 1'b1);
            chk($sformatf("t4_x%0d", k), mx_b, 9'd300);
            chk($sformatf("t4_s_ready%0d", k), s_ready_b, 4'b0000);
            @(negedge clock);
        end
        chk("t4_w_zero", mw_b, 9'd0);
        chk("t4_h", mh_b, 9'd511);
        man_rdy_b = 1'b1;
        @(negedge clock);
        chk("t4_busy_m_valid", m_valid_b, 1'b0);
        @(negedge clock);
        chk("t4_first_busy_ignores_ready", s_done_b, 4'b0000);
        man_rdy_b = 1'b0;
        @(negedge clock);
        @(negedge clock);
        man_rdy_b = 1'b1;
        wait_done_b(d);
        chk("t4_done", d, 4'b0100);
        chk("t4_next_ready", s_ready_b, 4'b0001);
        drw_en_b = 1'b1;
        @(negedge clock);
        s_valid = 4'b0000;
        wait_done_b(d);
        chk("t4_done_next", d, 4'b0001);

        // 5: drawer never returns ready -> timeout after 16 busy cycles
        drw_en_b = 1'b0;
        man_rdy_b = 1'b1;
        @(negedge clock);
        s_valid = 4'b1000;
        @(negedge clock);
        s_valid = 4'b0000;
        @(negedge clock);
        man_rdy_b = 1'b0;
        chk("t5_in_busy", m_valid_b, 1'b0);
        chk("t5_no_err_yet", terr_b, 1'b0);
        nt = 0;
        d = 4'b0000;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (s_done_b != 4'b0000) begin
                nt = n;
                d = s_done_b;
                break;
            end
        end
        chk("t5_busy_cycles", nt, 16);
        chk("t5_done", d, 4'b1000);
        chk("t5_timeout_err", terr_b, 1'b1);
        man_rdy_b = 1'b1;
        drw_en_b = 1'b1;
        s_valid = 4'b0010;
        #1 chk("t5_next_ready", s_ready_b, 4'b0010);
        @(negedge clock);
        s_valid = 4'b0000;
        wait_done_b(d);
        chk("t5_next_done", d, 4'b0010);
        chk("t5_err_sticky", terr_b, 1'b1);

        // 6: reset while busy abandons the box and restarts arbitration
        @(negedge clock);
        s_valid = 4'b0100;
        @(negedge clock);
        s_valid = 4'b0101;
        @(negedge clock);
        chk("t6_in_busy", m_valid_b, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t6_m_valid", m_valid_b, 1'b0);
        chk("t6_s_done", s_done_b, 4'b0000);
        chk("t6_timeout_err", terr_b, 1'b0);
        chk("t6_s_ready", s_ready_b, 4'b0000);
        chk("t6_m_box_x", mx_b, 9'd0);
        chk("t6_grant_id", gid_b, 2'd2 & 2'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("t6_bg_first", s_ready_b, 4'b0001);
        chk("t6_rr_first", s_ready_r, 4'b0001);
        chk("t6_no_done", s_done_b, 4'b0000);
        @(negedge clock);
        s_valid = 4'b0000;
        repeat (20) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
